// File: rtl/dice_race_pkg.sv
// Shared types for the dice event qualifier: die color code and FSM state.
package dice_race_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [1:0] {
    WAIT_CLEAR = 2'd0,
    ARMED      = 2'd1,
    CONFIRM    = 2'd2,
    HOLD       = 2'd3
  } state_t;

  // Saturating 4-bit increment for the match counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/dice_event_qualifier.sv
// Dice event qualifier: accepts a die color once it has been classified the
// same way on CONFIRM_FRAMES consecutive samples after an empty white tray,
// then holds it until the consumer takes it.
// Optional macro DICE_TIMEOUT_EN: abandon CONFIRM after TIMEOUT_FRAMES frame
// ticks. Without it frame_tick is unused and CONFIRM waits indefinitely.
//
// state      | meaning
// WAIT_CLEAR | waiting for an empty white tray before a new roll
// ARMED      | tray seen empty, waiting for the first classification
// CONFIRM    | counting consecutive identical classifications
// HOLD       | qualified roll presented, waiting for dice_ready
module dice_event_qualifier
  import dice_race_pkg::*;
#(
  parameter int CONFIRM_FRAMES = 3,
  parameter int TIMEOUT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       result_ready,
  input  logic [1:0] stable_color,
  input  logic       white_stable,
  input  logic       dice_ready,
  output logic       dice_valid,
  output logic [1:0] dice_value,
  output logic       busy
);

  localparam logic [3:0] CONFIRM_CNT = 4'(CONFIRM_FRAMES);

  state_t     state;
  color_t     cand;
  logic [3:0] match_cnt;
  logic [3:0] match_next;
  logic       qualify;
  logic       tmo_hit;

  // Match count that the current sample would produce; ARMED always starts at 1.
  always_comb begin
    match_next = 4'd1;
    if (state == CONFIRM && stable_color == cand) match_next = sat_inc4(match_cnt);
    qualify = result_ready && (match_next >= CONFIRM_CNT);
  end

`ifdef DICE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_FRAMES);
  logic [7:0] tmo_cnt;

  assign tmo_hit = frame_tick && (tmo_cnt == TIMEOUT_CNT - 8'd1);

  // Frame counter lives only while in CONFIRM, so it is zero on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 tmo_cnt <= 8'd0;
    else if (state != CONFIRM)  tmo_cnt <= 8'd0;
    else if (frame_tick)        tmo_cnt <= tmo_cnt + 8'd1;
  end
`else
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = frame_tick ^ (TIMEOUT_FRAMES == 0);
`endif

  // Main sequencing FSM with registered roll outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_CLEAR;
      cand       <= 2'd0;
      match_cnt  <= 4'd0;
      dice_valid <= 1'b0;
      dice_value <= 2'd0;
    end else begin
      case (state)
        WAIT_CLEAR: begin
          if (white_stable) state <= ARMED;
        end
        ARMED: begin
          if (result_ready && !white_stable) begin
            cand <= stable_color;
            if (qualify) begin
              state      <= HOLD;
              match_cnt  <= 4'd0;
              dice_valid <= 1'b1;
              dice_value <= stable_color;
            end else begin
              state     <= CONFIRM;
              match_cnt <= 4'd1;
            end
          end
        end
        CONFIRM: begin
          if (white_stable) begin
            state     <= ARMED;
            match_cnt <= 4'd0;
          end else if (qualify) begin
            // A qualifying sample wins over a coincident timeout.
            state      <= HOLD;
            cand       <= stable_color;
            match_cnt  <= 4'd0;
            dice_valid <= 1'b1;
            dice_value <= stable_color;
          end else if (tmo_hit) begin
            state     <= WAIT_CLEAR;
            match_cnt <= 4'd0;
          end else if (result_ready) begin
            cand      <= stable_color;
            match_cnt <= match_next;
          end
        end
        HOLD: begin
          if (dice_ready) begin
            state      <= WAIT_CLEAR;
            dice_valid <= 1'b0;
          end
        end
        default: state <= WAIT_CLEAR;
      endcase
    end
  end

  assign busy = (state == CONFIRM) || (state == HOLD);

endmodule

// File: tb/tb_dice_event_qualifier.sv
// Self-checking bench for dice_event_qualifier: vector table, directed corner
// sequences and a randomized run against a queue-based roll model.
module tb_dice_event_qualifier;

  localparam int CF = 3;
  localparam int TF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       result_ready = 1'b0;
  logic [1:0] stable_color = 2'd0;
  logic       white_stable = 1'b0;
  logic       dice_ready = 1'b0;
  logic       dice_valid, busy;
  logic [1:0] dice_value;
  logic       v1, b1;
  logic [1:0] val1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dice_event_qualifier #(.CONFIRM_FRAMES(CF), .TIMEOUT_FRAMES(TF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .result_ready(result_ready),
    .stable_color(stable_color), .white_stable(white_stable), .dice_ready(dice_ready),
    .dice_valid(dice_valid), .dice_value(dice_value), .busy(busy));

  dice_event_qualifier #(.CONFIRM_FRAMES(1), .TIMEOUT_FRAMES(TF)) dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .result_ready(result_ready),
    .stable_color(stable_color), .white_stable(white_stable), .dice_ready(dice_ready),
    .dice_valid(v1), .dice_value(val1), .busy(b1));

  // Reference model: a roll is a run of identical samples seen after a white tray.
  bit   m_seen_white;
  int   m_streak[$];
  bit   m_hold;
  int   m_value;
  int   m_ticks;

  task automatic model_reset();
    m_seen_white = 0; m_streak.delete(); m_hold = 0; m_value = 0; m_ticks = 0;
  endtask

  task automatic model_step(input bit rr, input int c, input bit w, input bit rdy, input bit ft);
    int n;
    if (m_hold) begin
      if (rdy) begin m_hold = 0; m_seen_white = 0; end
    end else if (!m_seen_white) begin
      if (w) m_seen_white = 1;
    end else if (m_streak.size() == 0) begin
      if (rr && !w) begin
        m_streak.push_back(c); m_ticks = 0;
        if (CF == 1) begin m_hold = 1; m_value = c; m_streak.delete(); end
      end
    end else begin
      n = (c == m_streak[$]) ? m_streak.size() + 1 : 1;
      if (w) begin
        m_streak.delete();
      end else if (rr && n >= CF) begin
        m_hold = 1; m_value = c; m_streak.delete();
`ifdef DICE_TIMEOUT_EN
      end else if (ft && m_ticks + 1 == TF) begin
        m_streak.delete(); m_seen_white = 0;
`endif
      end else begin
        if (ft) m_ticks++;
        if (rr) begin
          if (n == 1) m_streak.delete();
          m_streak.push_back(c);
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rr, input int c, input bit w, input bit rdy, input bit ft);
    result_ready = rr; stable_color = 2'(c); white_stable = w; dice_ready = rdy; frame_tick = ft;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    step(); step();
    #2 reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit rr; int c; bit w; bit rdy;
    bit ev; int eval; bit eb;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int last_c;
    tbl[0]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 2, 0, 1, 0, 0, 1};
    tbl[2]  = '{1, 2, 0, 1, 0, 0, 1};
    tbl[3]  = '{1, 2, 0, 1, 1, 2, 1};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 3, 0, 0, 0, 0, 1};
    tbl[9]  = '{1, 3, 0, 0, 0, 0, 1};
    tbl[10] = '{1, 3, 0, 0, 1, 3, 1};
    tbl[11] = '{0, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{1, 2, 0, 0, 0, 0, 0};

    // Reset state
    step(); step();
    chk("reset_valid", dice_valid, 0);
    chk("reset_value", dice_value, 0);
    chk("reset_busy", busy, 0);
    #2 reset = 1'b1;

    // Table: basic roll, then a color change that must yield a single roll of 3
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rr, tbl[i].c, tbl[i].w, tbl[i].rdy, 0);
      step();
      chk($sformatf("tbl%0d_valid", i), dice_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      if (tbl[i].ev) chk($sformatf("tbl%0d_value", i), dice_value, tbl[i].eval);
    end

    // Long HOLD with ignored traffic, then handshake and no roll until white
    drive(0, 0, 1, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 0, 0); step(); end
    chk("hold_enter_valid", dice_valid, 1);
    for (int i = 0; i < 100; i++) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0, 0);
      step();
      chk("hold_valid", dice_valid, 1);
      chk("hold_value", dice_value, 1);
    end
    drive(0, 0, 0, 1, 0); step();
    chk("hold_release_valid", dice_valid, 0);
    chk("hold_release_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0); step();
      chk("post_hold_no_roll", dice_valid, 0);
      chk("post_hold_busy", busy, 0);
    end

    // White beats result_ready in CONFIRM, and the match count restarts
    drive(0, 0, 1, 0, 0); step();
    drive(1, 2, 0, 0, 0); step();
    drive(1, 2, 0, 0, 0); step();
    drive(1, 2, 1, 0, 0); step();
    chk("white_prio_busy", busy, 0);
    chk("white_prio_valid", dice_valid, 0);
    drive(1, 2, 0, 0, 0); step();
    drive(1, 2, 0, 0, 0); step();
    chk("recount_busy", busy, 1);
    chk("recount_valid", dice_valid, 0);
    drive(1, 2, 0, 0, 0); step();
    chk("recount_roll", dice_valid, 1);
    chk("recount_value", dice_value, 2);
    drive(0, 0, 0, 1, 0); step();

    // Timeout behaviour
    drive(0, 0, 1, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    chk("tmo_confirm_busy", busy, 1);
    for (int i = 0; i < TF - 1; i++) begin
      drive(0, 0, 0, 0, 1); step();
      chk("tmo_pre_busy", busy, 1);
    end
    drive(0, 0, 0, 0, 1); step();
`ifdef DICE_TIMEOUT_EN
    chk("tmo_busy", busy, 0);
    chk("tmo_valid", dice_valid, 0);
    drive(1, 1, 0, 0, 0); step();
    chk("tmo_needs_white", busy, 0);
`else
    chk("no_tmo_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1); step();
      chk("no_tmo_persist", busy, 1);
    end
    drive(0, 0, 1, 0, 0); step();
    chk("no_tmo_white_exit", busy, 0);
`endif

    // CONFIRM_FRAMES=1 instance: roll one cycle after the first sample
    drive(0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 1, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    chk("cf1_valid", v1, 1);
    chk("cf1_value", val1, 1);
    chk("cf1_busy", b1, 1);
    chk("cf3_not_yet", dice_valid, 0);

    // Asynchronous reset during HOLD
    drive(0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 1, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, 3, 0, 0, 0); step(); end
    chk("pre_reset_valid", dice_valid, 1);
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", dice_valid, 0);
    chk("async_reset_busy", busy, 0);
    step();
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 0, 0, 0); step();
      chk("post_reset_no_roll", dice_valid, 0);
    end

    // Randomized run against the model
    drive(0, 0, 0, 0, 0);
    do_reset();
    last_c = 0;
    for (int i = 0; i < 2000; i++) begin
      bit rr, w, rdy, ft;
      int c;
      rr  = ($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 3) != 0) ? last_c : int'($urandom_range(0, 3));
      last_c = c;
      w   = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) == 0);
      ft  = ($urandom_range(0, 4) == 0);
      drive(rr, c, w, rdy, ft);
      @(posedge clk);
      model_step(rr, c, w, rdy, ft);
      #1;
      chk("rand_valid", dice_valid, int'(m_hold));
      chk("rand_busy", busy, int'(m_hold || m_streak.size() != 0));
      if (m_hold) chk("rand_value", dice_value, m_value);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dice_event_qualifier.md
DICE_EVENT_QUALIFIER -- requirements
Module: dice_event_qualifier

Interface
REQ-001 SHALL have parameter CONFIRM_FRAMES, default 3: consecutive matching classifications needed to accept a roll (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_FRAMES, default 60: frame ticks allowed in CONFIRM before abandoning (range 1..255).
REQ-003 SHALL have port clk, input, 1: single clock; the block has one clock.
REQ-004 SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-005 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-006 SHALL have port result_ready, input, 1: one-cycle pulse, classification sample valid.
REQ-007 SHALL have port stable_color, input, 2: classified die color code (0..3).
REQ-008 SHALL have port white_stable, input, 1: level, empty white tray seen.
REQ-009 SHALL have port dice_ready, input, 1: consumer accepts dice_value.
REQ-010 SHALL have port dice_valid, output, 1: qualified roll available.
REQ-011 SHALL have port dice_value, output, 2: qualified color code.
REQ-012 SHALL have port busy, output, 1: high in CONFIRM or HOLD.

Function
REQ-013 SHALL implement states WAIT_CLEAR, ARMED, CONFIRM, HOLD.
REQ-014 WAIT_CLEAR -> ARMED on any cycle with white_stable=1; WAIT_CLEAR ignores result_ready.
REQ-015 ARMED -> CONFIRM on result_ready with white_stable=0: capture stable_color into cand, match_cnt=1.
REQ-016 In CONFIRM, result_ready with stable_color==cand SHALL increment match_cnt (saturating 4 bits); with a different color, cand is reloaded and match_cnt=1.
REQ-017 In CONFIRM, white_stable=1 SHALL return to ARMED and clear match_cnt; white_stable takes priority over a simultaneous result_ready.
REQ-018 When match_cnt reaches CONFIRM_FRAMES, the next cycle SHALL enter HOLD with dice_valid=1, dice_value=cand; latency = one clk after the qualifying result_ready.
REQ-019 CONFIRM_FRAMES=1 SHALL enter HOLD one cycle after the first result_ready in ARMED.
REQ-020 In HOLD, dice_valid and dice_value SHALL stay stable until dice_valid&dice_ready; transfer then goes to WAIT_CLEAR with dice_valid=0 next cycle.
REQ-021 In HOLD, result_ready and white_stable SHALL be ignored; no second roll is buffered.
REQ-022 dice_ready while dice_valid=0 SHALL have no effect.
REQ-023 busy SHALL be combinational from state.

Reset
REQ-024 Asserting reset (low) SHALL asynchronously force WAIT_CLEAR, dice_valid=0, dice_value=0, busy=0, match_cnt=0, cand=0, timeout count=0.
REQ-025 Reset during HOLD SHALL drop dice_valid immediately; no roll is reported after release until white is seen.

Configuration
REQ-026 With macro DICE_TIMEOUT_EN defined, a frame counter SHALL count frame_tick in CONFIRM, clear on entry; reaching TIMEOUT_FRAMES returns to WAIT_CLEAR, clearing match_cnt.
REQ-027 Without DICE_TIMEOUT_EN, no counter SHALL exist, frame_tick SHALL be unused, and CONFIRM persists indefinitely.
REQ-028 If timeout and the qualifying result_ready coincide, the roll SHALL win (enter HOLD).

Structure
REQ-029 Package dice_race_pkg SHALL hold the 2-bit color typedef and the state enum typedef.
REQ-030 No sub-module SHALL be used; timeout counter is inline under the macro.

Verification
REQ-031 white, then 3 result_ready color=2, ready=1 -> dice_valid one cycle after third pulse, value=2, drops after handshake.
REQ-032 Colors 1,1,3,3,3 after white -> single roll value=3; no roll for color 1.
REQ-033 HOLD with dice_ready=0 for 100 cycles plus color pulses -> dice_valid, value unchanged; raise ready -> WAIT_CLEAR; color pulses then produce no roll until white.
REQ-034 white_stable and result_ready same cycle in CONFIRM (match_cnt=2) -> state ARMED, match_cnt=0.
REQ-035 DICE_TIMEOUT_EN, TIMEOUT_FRAMES=4: one pulse then 4 frame_ticks -> WAIT_CLEAR, busy=0, no dice_valid.
REQ-036 reset low mid-HOLD -> dice_valid=0 same cycle asynchronously; after release, color pulses without white give no roll.
